// File: rtl/ad9276_spi_init_seq_pkg.sv
// ============================================================================
//  Module      : ad9276_spi_pkg
//  Description : Shared register map, status bit positions and FSM encodings
//                for the AD9276 SPI init sequencer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package ad9276_spi_pkg;

    localparam logic [2:0] REG_RX      = 3'd0;
    localparam logic [2:0] REG_TX      = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;

    localparam int ST_E    = 8;
    localparam int ST_RRDY = 7;
    localparam int ST_TRDY = 6;
    localparam int ST_TMT  = 5;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CLR_ST  = 4'd1,
        S_FETCH   = 4'd2,
        S_POLL_TX = 4'd3,
        S_WR_TX   = 4'd4,
        S_POLL_RX = 4'd5,
        S_RD_RX   = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } seq_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACC1 = 2'd1,
        BUS_ACC2 = 2'd2,
        BUS_GAP  = 2'd3
    } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/ad9276_spi_init_seq_if.sv
// ============================================================================
//  Module      : ad9276_spi_init_seq_if
//  Description : Avalon-style register bus between the sequencer and the
//                SPI master core.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface ad9276_spi_init_seq_if;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu
    );

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu
    );
endinterface

`default_nettype wire

// File: rtl/ad9276_spi_bus_access.sv
// ============================================================================
//  Module      : ad9276_spi_bus_access
//  Description : Two-cycle register access engine with a mandatory idle gap.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ad9276_spi_bus_access
    import ad9276_spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    ad9276_spi_init_seq_if.master bus
);

    bus_state_t state;

    // The gap state guarantees strobes return high before a new request is
    // sampled, so a requester holding req across ack never re-triggers early.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= BUS_IDLE;
            ack               <= 1'b0;
            rdata             <= '0;
            bus.spi_select    <= 1'b0;
            bus.mem_addr      <= '0;
            bus.read_n        <= 1'b1;
            bus.write_n       <= 1'b1;
            bus.data_from_cpu <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                BUS_IDLE: begin
                    if (req) begin
                        bus.spi_select    <= 1'b1;
                        bus.mem_addr      <= addr;
                        bus.data_from_cpu <= wdata;
                        bus.read_n        <= we;
                        bus.write_n       <= ~we;
                        state             <= BUS_ACC1;
                    end
                end
                BUS_ACC1: state <= BUS_ACC2;
                BUS_ACC2: begin
                    rdata          <= bus.data_to_cpu;
                    ack            <= 1'b1;
                    bus.spi_select <= 1'b0;
                    bus.read_n     <= 1'b1;
                    bus.write_n    <= 1'b1;
                    state          <= BUS_GAP;
                end
                BUS_GAP:  state <= BUS_IDLE;
                default:  state <= BUS_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ad9276_spi_init_seq.sv
// ============================================================================
//  Module      : ad9276_spi_init_seq
//  Description : Streams NUM_CMDS ROM words through the SPI core, polling
//                status between words and returning each received word.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ad9276_spi_init_seq
    import ad9276_spi_pkg::*;
#(
    parameter int NUM_CMDS   = 16,
    parameter int IDX_W      = 4,
    parameter int POLL_LIMIT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] cmd_idx,
    input  logic [23:0]      cmd_word,
    output logic             rd_valid,
    output logic [23:0]      rd_word,
    output logic [IDX_W-1:0] rd_idx,
    ad9276_spi_init_seq_if.master bus
);

    localparam int PCNT_W = $clog2(POLL_LIMIT + 1);

    seq_state_t        state;
    logic [23:0]       word;
    logic [PCNT_W-1:0] poll_cnt;
    logic              req;
    logic              we;
    logic [2:0]        addr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              poll_expired;
    logic              unused_rdata;

    assign poll_expired = (poll_cnt >= PCNT_W'(POLL_LIMIT - 1));
    assign unused_rdata = ^rdata[31:24];

    always_comb begin
        req   = 1'b0;
        we    = 1'b0;
        addr  = REG_STATUS;
        wdata = '0;
        case (state)
            S_CLR_ST:             begin req = 1'b1; we = 1'b1; end
            S_POLL_TX, S_POLL_RX: req = 1'b1;
            S_WR_TX:              begin req = 1'b1; we = 1'b1; addr = REG_TX; wdata = {8'h00, word}; end
            S_RD_RX:              begin req = 1'b1; addr = REG_RX; end
            default:              req = 1'b0;
        endcase
    end

    ad9276_spi_bus_access u_bus (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .bus   (bus)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cmd_idx  <= '0;
            rd_valid <= 1'b0;
            rd_word  <= '0;
            rd_idx   <= '0;
            word     <= '0;
            poll_cnt <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done    <= 1'b0;
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        cmd_idx <= '0;
                        state   <= S_CLR_ST;
                    end
                end
                S_CLR_ST: if (ack) state <= S_FETCH;
                S_FETCH: begin
                    word     <= cmd_word;
                    poll_cnt <= '0;
                    state    <= S_POLL_TX;
                end
                S_POLL_TX: begin
                    if (ack) begin
                        if (rdata[ST_E])                      state <= S_ERR;
                        else if (rdata[ST_TRDY] && rdata[ST_TMT]) state <= S_WR_TX;
                        else if (poll_expired)                state <= S_ERR;
                        else                                  poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                S_WR_TX: begin
                    if (ack) begin
                        poll_cnt <= '0;
                        state    <= S_POLL_RX;
                    end
                end
                S_POLL_RX: begin
                    if (ack) begin
                        if (rdata[ST_E])                      state <= S_ERR;
                        else if (rdata[ST_TMT] && rdata[ST_RRDY]) state <= S_RD_RX;
                        else if (poll_expired)                state <= S_ERR;
                        else                                  poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                S_RD_RX: begin
                    if (ack) begin
                        rd_valid <= 1'b1;
                        rd_word  <= rdata[23:0];
                        rd_idx   <= cmd_idx;
                        if (cmd_idx == IDX_W'(NUM_CMDS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            cmd_idx <= cmd_idx + IDX_W'(1);
                            state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
